// File: rtl/matrix_multiplier_pk.sv
// Shared dimensions of the systolic matrix multiplier and the operand feeder FSM states.
package matrix_multiplier_pk;

  localparam int unsigned NOF_ROWS_MATRIX_A = 8;
  localparam int unsigned NOF_COLS_MATRIX_A = 8;
  localparam int unsigned NOF_ROWS_MATRIX_B = 8;
  localparam int unsigned NOF_COLS_MATRIX_B = 8;
  localparam int unsigned PE_LATENCY        = 1;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StDone
  } feeder_state_t;

endpackage

// File: rtl/operand_skew_feeder.sv
// Captures A/B operands and streams them diagonally skewed onto the west/north edges of the
// PE array, then drains the pipeline and pulses done once every accumulator is final.
module operand_skew_feeder
  import matrix_multiplier_pk::*;
#(
  parameter int unsigned INPUT_DATA_WIDTH = 8
) (
  input  logic                                                                    clk,
  input  logic                                                                    rst_n,
  input  logic                                                                    start,
  input  logic                                                                    abort,
  input  logic [NOF_ROWS_MATRIX_A-1:0][NOF_COLS_MATRIX_A-1:0][INPUT_DATA_WIDTH-1:0] mat_a,
  input  logic [NOF_ROWS_MATRIX_B-1:0][NOF_COLS_MATRIX_B-1:0][INPUT_DATA_WIDTH-1:0] mat_b,
  output logic                                                                    ready,
  output logic [NOF_ROWS_MATRIX_A-1:0][INPUT_DATA_WIDTH-1:0]                      a_edge,
  output logic [NOF_COLS_MATRIX_B-1:0][INPUT_DATA_WIDTH-1:0]                      b_edge,
  output logic                                                                    acc_clear,
  output logic                                                                    pe_enable,
  output logic                                                                    done
);

  localparam int unsigned W     = INPUT_DATA_WIDTH;
  localparam int unsigned RowsA = NOF_ROWS_MATRIX_A;
  localparam int unsigned ColsB = NOF_COLS_MATRIX_B;
  localparam int unsigned K     = NOF_COLS_MATRIX_A;

  localparam int unsigned StreamCycles = K + ((RowsA > ColsB) ? RowsA : ColsB) - 1;
  localparam int unsigned DrainCycles  = ColsB - 1 + PE_LATENCY;
  localparam int unsigned MaxCycles    = (StreamCycles > DrainCycles) ? StreamCycles : DrainCycles;
  localparam int unsigned CntW         = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam int unsigned KW           = (K > 1) ? $clog2(K) : 1;

  localparam logic [CntW-1:0] LastStep  = CntW'(StreamCycles - 1);
  localparam logic [CntW-1:0] LastDrain = CntW'((DrainCycles > 0) ? DrainCycles - 1 : 0);

  typedef logic [RowsA-1:0][K-1:0][W-1:0] mat_a_t;
  typedef logic [K-1:0][ColsB-1:0][W-1:0] mat_b_t;
  typedef logic [RowsA-1:0][W-1:0]        a_vec_t;
  typedef logic [ColsB-1:0][W-1:0]        b_vec_t;

  feeder_state_t   state_q;
  logic [CntW-1:0] step_q;
  mat_a_t          a_cap_q;
  mat_b_t          b_cap_q;
  a_vec_t          a_edge_q;
  b_vec_t          b_edge_q;
  logic            pe_enable_q;
  logic            done_q;

  logic            accept;
  logic [CntW-1:0] load_step;
  mat_a_t          a_src;
  mat_b_t          b_src;
  a_vec_t          a_skew;
  b_vec_t          b_skew;

  assign ready  = (state_q == StIdle);
  assign accept = ready && start && !abort;

  // In the accept cycle the step-0 edges come straight from the inputs being captured.
  assign a_src     = ready ? mat_a : a_cap_q;
  assign b_src     = ready ? mat_b : b_cap_q;
  assign load_step = ready ? '0 : step_q + CntW'(1);

  // The extra top bit of each difference flags a negative offset, which also fails the
  // upper bound compare because the wrapped value always exceeds K.
  for (genvar i = 0; i < RowsA; i++) begin : g_a_skew
    logic [CntW:0] diff;
    assign diff      = {1'b0, load_step} - (CntW + 1)'(i);
    assign a_skew[i] = (diff < (CntW + 1)'(K)) ? a_src[i][diff[KW-1:0]] : '0;
  end

  for (genvar j = 0; j < ColsB; j++) begin : g_b_skew
    logic [CntW:0] diff;
    assign diff      = {1'b0, load_step} - (CntW + 1)'(j);
    assign b_skew[j] = (diff < (CntW + 1)'(K)) ? b_src[diff[KW-1:0]][j] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      step_q      <= '0;
      a_cap_q     <= '0;
      b_cap_q     <= '0;
      a_edge_q    <= '0;
      b_edge_q    <= '0;
      pe_enable_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= StIdle;
      step_q      <= '0;
      a_edge_q    <= '0;
      b_edge_q    <= '0;
      pe_enable_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_cap_q     <= mat_a;
            b_cap_q     <= mat_b;
            a_edge_q    <= a_skew;
            b_edge_q    <= b_skew;
            pe_enable_q <= 1'b1;
            step_q      <= '0;
            state_q     <= StStream;
          end
        end
        StStream: begin
          if (step_q == LastStep) begin
            a_edge_q <= '0;
            b_edge_q <= '0;
            step_q   <= '0;
            if (DrainCycles > 0) begin
              state_q <= StDrain;
            end else begin
              state_q     <= StDone;
              pe_enable_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end else begin
            a_edge_q <= a_skew;
            b_edge_q <= b_skew;
            step_q   <= load_step;
          end
        end
        StDrain: begin
          if (step_q == LastDrain) begin
            state_q     <= StDone;
            step_q      <= '0;
            pe_enable_q <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            step_q <= step_q + CntW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          step_q  <= '0;
        end
        default: begin
          state_q <= StIdle;
          step_q  <= '0;
        end
      endcase
    end
  end

  assign a_edge    = a_edge_q;
  assign b_edge    = b_edge_q;
  assign acc_clear = accept;
  assign pe_enable = pe_enable_q;
  assign done      = done_q;

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Self-checking bench for operand_skew_feeder: skew table, directed corner cases and random ops.
module tb_operand_skew_feeder;
  import matrix_multiplier_pk::*;

  localparam int W   = 8;
  localparam int RA  = NOF_ROWS_MATRIX_A;
  localparam int K   = NOF_COLS_MATRIX_A;
  localparam int CB  = NOF_COLS_MATRIX_B;
  localparam int S   = K + ((RA > CB) ? RA : CB) - 1;
  localparam int D   = CB - 1 + PE_LATENCY;
  localparam int LAT = S + D + 1;

  typedef logic [RA-1:0][K-1:0][W-1:0] mat_a_t;
  typedef logic [K-1:0][CB-1:0][W-1:0] mat_b_t;
  typedef logic [RA-1:0][W-1:0]        aedge_t;
  typedef logic [CB-1:0][W-1:0]        bedge_t;

  typedef struct {
    int         n;
    int         lane;
    logic [7:0] val;
  } skew_vec_t;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   start;
  logic   abort;
  mat_a_t mat_a;
  mat_b_t mat_b;
  logic   ready;
  aedge_t a_edge;
  bedge_t b_edge;
  logic   acc_clear;
  logic   pe_enable;
  logic   done;

  operand_skew_feeder #(.INPUT_DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .mat_a    (mat_a),
    .mat_b    (mat_b),
    .ready    (ready),
    .a_edge   (a_edge),
    .b_edge   (b_edge),
    .acc_clear(acc_clear),
    .pe_enable(pe_enable),
    .done     (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  aedge_t a_tr   [64];
  bedge_t b_tr   [64];
  logic   pe_tr  [64];
  logic   done_tr[64];
  logic   rdy_tr [64];
  logic   acc_tr [64];

  task automatic check(input string name, input int n, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s idx=%0d got=%h want=%h", name, n, act, exp);
    end
  endtask

  function automatic mat_a_t rand_a();
    mat_a_t r;
    for (int i = 0; i < RA; i++)
      for (int k = 0; k < K; k++) r[i][k] = W'($urandom);
    return r;
  endfunction

  function automatic mat_b_t rand_b();
    mat_b_t r;
    for (int k = 0; k < K; k++)
      for (int j = 0; j < CB; j++) r[k][j] = W'($urandom);
    return r;
  endfunction

  // Reference edges for step t, straight from the diagonal skew rule.
  function automatic aedge_t exp_a(input mat_a_t A, input int t);
    aedge_t r = '0;
    for (int i = 0; i < RA; i++)
      if (t - i >= 0 && t - i < K) r[i] = A[i][t-i];
    return r;
  endfunction

  function automatic bedge_t exp_b(input mat_b_t B, input int t);
    bedge_t r = '0;
    for (int j = 0; j < CB; j++)
      if (t - j >= 0 && t - j < K) r[j] = B[t-j][j];
    return r;
  endfunction

  // Cycle n=1 is the cycle after the accept edge; inputs set in cycle n act at its end.
  task automatic run_op(input mat_a_t A, input mat_b_t B, input int abort_n, input int busy_n,
                        input int ncyc);
    @(negedge clk);
    mat_a = A;
    mat_b = B;
    start = 1'b1;
    abort = 1'b0;
    #1;
    check("accept_ready", 0, 64'(ready), 64'(1));
    check("accept_clear", 0, 64'(acc_clear), 64'(1));
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      a_tr[n]    = a_edge;
      b_tr[n]    = b_edge;
      pe_tr[n]   = pe_enable;
      done_tr[n] = done;
      rdy_tr[n]  = ready;
      start      = (n == busy_n);
      abort      = (n == abort_n);
      mat_a      = rand_a();
      mat_b      = rand_b();
      #1;
      acc_tr[n] = acc_clear;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_model(input mat_a_t A, input mat_b_t B, input int abort_n, input int ncyc);
    for (int n = 1; n <= ncyc; n++) begin
      bit     live = (abort_n == 0) || (n <= abort_n);
      aedge_t ea   = (live && n <= S) ? exp_a(A, n - 1) : '0;
      bedge_t eb   = (live && n <= S) ? exp_b(B, n - 1) : '0;
      check("a_edge", n, 64'(a_tr[n]), 64'(ea));
      check("b_edge", n, 64'(b_tr[n]), 64'(eb));
      check("pe_enable", n, 64'(pe_tr[n]), 64'(live && n <= S + D));
      check("done", n, 64'(done_tr[n]), 64'(live && n == LAT));
      check("ready", n, 64'(rdy_tr[n]), 64'(!(live && n <= LAT)));
      check("acc_clear_busy", n, 64'(acc_tr[n]), 64'(0));
    end
  endtask

  // Output-stationary array fed from the recorded edges: PE(i,j) sees row i delayed by j
  // and column j delayed by i.
  task automatic check_product(input mat_a_t A, input mat_b_t B);
    for (int i = 0; i < RA; i++) begin
      for (int j = 0; j < CB; j++) begin
        int c   = 0;
        int ref_c = 0;
        for (int n = 1; n <= S + D; n++)
          if (pe_tr[n] && n - j >= 1 && n - i >= 1)
            c += int'(a_tr[n-j][i]) * int'(b_tr[n-i][j]);
        for (int k = 0; k < K; k++) ref_c += int'(A[i][k]) * int'(B[k][j]);
        check("product", i * CB + j, 64'(c), 64'(ref_c));
      end
    end
  endtask

  initial begin
    mat_a_t    A;
    mat_b_t    B;
    skew_vec_t tbl[16];
    int        acc_cnt;
    int        done_cnt;
    int        first_done;
    int        last_done;

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mat_a = '0;
    mat_b = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_edge", 0, 64'(a_edge), 64'(0));
    check("rst_b_edge", 0, 64'(b_edge), 64'(0));
    check("rst_pe_enable", 0, 64'(pe_enable), 64'(0));
    check("rst_done", 0, 64'(done), 64'(0));
    check("rst_acc_clear", 0, 64'(acc_clear), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 0, 64'(ready), 64'(1));

    // Identity A, B[r][c] = r*8+c: product must reproduce B.
    for (int i = 0; i < RA; i++)
      for (int k = 0; k < K; k++) A[i][k] = (i == k) ? W'(1) : W'(0);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < CB; c++) B[r][c] = W'(r * 8 + c);
    run_op(A, B, 0, 0, LAT + 2);
    check_model(A, B, 0, LAT + 2);
    check_product(A, B);

    // Skew table on lane 3 and the corner lanes.
    tbl[0]  = '{1, 3, 8'h00};
    tbl[1]  = '{2, 3, 8'h00};
    tbl[2]  = '{3, 3, 8'h00};
    for (int k = 0; k < 8; k++) tbl[3+k] = '{4 + k, 3, 8'(8'h31 + k)};
    tbl[11] = '{12, 3, 8'h00};
    tbl[12] = '{15, 3, 8'h00};
    tbl[13] = '{1, 0, 8'h01};
    tbl[14] = '{8, 7, 8'h71};
    tbl[15] = '{15, 7, 8'h78};
    for (int i = 0; i < RA; i++)
      for (int k = 0; k < K; k++) A[i][k] = W'(16 * i + k + 1);
    B = '0;
    run_op(A, B, 0, 0, LAT + 2);
    for (int v = 0; v < 16; v++)
      check("skew_tbl", v, 64'(a_tr[tbl[v].n][tbl[v].lane]), 64'(tbl[v].val));
    check_model(A, B, 0, LAT + 2);

    // start while busy, at stream step 5.
    A = rand_a();
    B = rand_b();
    run_op(A, B, 0, 6, LAT + 3);
    check_model(A, B, 0, LAT + 3);

    // Abort in the second drain cycle.
    A = rand_a();
    B = rand_b();
    run_op(A, B, S + 2, 0, LAT + 3);
    check_model(A, B, S + 2, LAT + 3);

    // abort together with start in IDLE: abort wins.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    #1;
    check("abort_start_clear", 0, 64'(acc_clear), 64'(0));
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_ready", 0, 64'(ready), 64'(1));
    check("abort_start_pe", 0, 64'(pe_enable), 64'(0));

    // Async reset between edges in the middle of STREAM.
    @(negedge clk);
    mat_a = rand_a();
    mat_b = rand_b();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_a_edge", 0, 64'(a_edge), 64'(0));
    check("mid_rst_b_edge", 0, 64'(b_edge), 64'(0));
    check("mid_rst_pe", 0, 64'(pe_enable), 64'(0));
    check("mid_rst_done", 0, 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_ready", 0, 64'(ready), 64'(1));
    A = rand_a();
    B = rand_b();
    run_op(A, B, 0, 0, LAT + 2);
    check_model(A, B, 0, LAT + 2);
    check_product(A, B);

    // Back-to-back with start held high.
    acc_cnt    = 0;
    done_cnt   = 0;
    first_done = -1;
    last_done  = -1;
    @(negedge clk);
    mat_a = rand_a();
    mat_b = rand_b();
    start = 1'b1;
    #1;
    if (acc_clear) acc_cnt++;
    for (int n = 1; n <= 2 * LAT + 2; n++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = n;
        last_done = n;
      end
      if (n == LAT + 1) check("b2b_ready", n, 64'(ready), 64'(1));
      if (n == 2 * LAT + 2) start = 1'b0;
      #1;
      if (acc_clear) acc_cnt++;
    end
    start = 1'b0;
    check("b2b_acc_clear_count", 0, 64'(acc_cnt), 64'(2));
    check("b2b_done_count", 0, 64'(done_cnt), 64'(2));
    check("b2b_first_done", 0, 64'(first_done), 64'(LAT));
    check("b2b_second_done", 0, 64'(last_done), 64'(2 * LAT + 1));
    @(negedge clk);
    @(negedge clk);

    // Random operations, some aborted mid-stream.
    for (int r = 0; r < 4; r++) begin
      int ab;
      A  = rand_a();
      B  = rand_b();
      ab = (r % 2 == 1) ? int'($urandom_range(1, S)) : 0;
      run_op(A, B, ab, 0, LAT + 2);
      check_model(A, B, ab, LAT + 2);
      if (ab == 0) check_product(A, B);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
